// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b, LSB first, one full-subtractor cell per clock.
// The result and borrow registers update only on the completion edge and hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic x, y, diff, br_next;

    // The single full-subtractor cell, fed by the low bits of the operand shifters.
    always_comb begin
        x       = sa_q[0];
        y       = sb_q[0];
        diff    = x ^ y ^ br_q;
        br_next = (~x & y) | (~(x ^ y) & br_q);
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    sr_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_d  = {diff, sr_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the full difference in the same edge as the shift.
                if (cnt_q == LAST_BIT) begin
                    d_d     = {diff, sr_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized checks of serial_subtractor against an arithmetic reference model.
// A 16-bit instance carries most tests; an 8-bit instance covers the parameter check.
module tb_serial_subtractor;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [W-1:0] last_d;
    logic         last_b;

    serial_subtractor_if #(.WIDTH(W)) bus16 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Must be called at a falling edge. Runs one full operation (E0..E17) and checks every cycle.
    // pokes: pulse start with a=7,b=7 on E3, E16 and E17. keep_start: start stays high throughout.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input bit pokes, input bit keep_start);
        logic [W:0]   wide;
        logic [W-1:0] exp_d;
        logic         exp_b;
        wide  = {1'b0, av} - {1'b0, bv};
        exp_d = wide[W-1:0];
        exp_b = (av < bv);

        bus16.start = 1'b1;
        bus16.a     = av;
        bus16.b     = bv;
        @(negedge clk);
        checkOutput("busy_after_accept", {31'd0, bus16.busy}, 32'd1);
        checkOutput("done_after_accept", {31'd0, bus16.done}, 32'd0);

        for (int k = 1; k <= W + 1; k++) begin
            if (pokes && (k == 3 || k == W || k == W + 1)) begin
                bus16.start = 1'b1;
                bus16.a     = 16'd7;
                bus16.b     = 16'd7;
            end else begin
                bus16.start = keep_start;
                bus16.a     = W'($urandom);
                bus16.b     = W'($urandom);
            end
            @(negedge clk);
            if (k < W) begin
                checkOutput("busy_run", {31'd0, bus16.busy}, 32'd1);
                checkOutput("done_run", {31'd0, bus16.done}, 32'd0);
                checkOutput("d_hold", {16'd0, bus16.d}, {16'd0, last_d});
                checkOutput("bout_hold", {31'd0, bus16.bout}, {31'd0, last_b});
            end else if (k == W) begin
                checkOutput("busy_done", {31'd0, bus16.busy}, 32'd0);
                checkOutput("done_pulse", {31'd0, bus16.done}, 32'd1);
                checkOutput("d_result", {16'd0, bus16.d}, {16'd0, exp_d});
                checkOutput("bout_result", {31'd0, bus16.bout}, {31'd0, exp_b});
                last_d = exp_d;
                last_b = exp_b;
            end else begin
                checkOutput("busy_idle", {31'd0, bus16.busy}, 32'd0);
                checkOutput("done_cleared", {31'd0, bus16.done}, 32'd0);
                checkOutput("d_kept", {16'd0, bus16.d}, {16'd0, last_d});
            end
        end
        bus16.start = keep_start;
    endtask

    initial begin
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        last_d      = '0;
        last_b      = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_busy", {31'd0, bus16.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus16.done}, 32'd0);
        checkOutput("rst_d", {16'd0, bus16.d}, 32'd0);
        checkOutput("rst_bout", {31'd0, bus16.bout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed subtractions, including underflow and equal operands
        applyStimulus(16'd0, 16'd1, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
        applyStimulus(16'h1234, 16'hFFFF, 1'b0, 1'b0);

        // start while RUN/DONE must be ignored
        applyStimulus(16'd100, 16'd58, 1'b1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("no_second_done", {31'd0, bus16.done}, 32'd0);
            checkOutput("no_second_busy", {31'd0, bus16.busy}, 32'd0);
            checkOutput("ignored_d", {16'd0, bus16.d}, 32'd42);
        end

        // Basic subtract, leaving d=4 ahead of the reset test
        applyStimulus(16'd5, 16'd1, 1'b0, 1'b0);
        checkOutput("basic_d", {16'd0, bus16.d}, 32'h0004);

        // Asynchronous reset in the middle of an operation
        bus16.start = 1'b1;
        bus16.a     = 16'hFFFF;
        bus16.b     = 16'd1;
        @(negedge clk);
        bus16.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, bus16.busy}, 32'd0);
        checkOutput("abort_done", {31'd0, bus16.done}, 32'd0);
        checkOutput("abort_d", {16'd0, bus16.d}, 32'd0);
        checkOutput("abort_bout", {31'd0, bus16.bout}, 32'd0);
        last_d = '0;
        last_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_done", {31'd0, bus16.done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'd3, 16'd5, 1'b0, 1'b0);

        // Held start: back-to-back random operations, one every W+2 cycles
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b1);
        end
        bus16.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_stopped", {31'd0, bus16.busy}, 32'd0);

        // Narrow instance: 0x10 - 0x20
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h20;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("w8_done_timing", {31'd0, bus8.done}, (k == 8) ? 32'd1 : 32'd0);
        end
        checkOutput("w8_d", {24'd0, bus8.d}, 32'h00F0);
        checkOutput("w8_bout", {31'd0, bus8.bout}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
